bids22_ctrl_sequencer: RTL and testbench

BIDS22_CTRL_SEQUENCER -- requirements
Module: bids22_ctrl_sequencer

---
 rtl/bids22_ctrl_sequencer_pkg.sv | 86 ++++++++
 rtl/bids22_ctrl_sequencer_if.sv | 10 +
 rtl/bids22_ctrl_sequencer.sv | 161 ++++++++++++++++
 tb/tb_bids22_ctrl_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bids22_ctrl_sequencer_pkg.sv
// Shared auction-FSM types plus the sequencer's state, config and step tables.
package bids22defs;

  localparam int DATAWIDTH = 32;
  localparam int NUM_STEPS = 8;
  // failstep code reported for errors seen while waiting for the round to end
  localparam logic [3:0] WAITOVER_STEP = 4'hF;

  typedef enum logic [3:0] {
    NO_OP        = 4'd0,
    UNLOCK       = 4'd1,
    LOCK         = 4'd2,
    LOADX        = 4'd3,
    LOADY        = 4'd4,
    LOADZ        = 4'd5,
    SETMASK      = 4'd6,
    SETTIMER     = 4'd7,
    SETBIDCHARGE = 4'd8
  } opcodes_t;

  typedef enum logic [2:0] {
    NOERROR         = 3'd0,
    BADKEY          = 3'd1,
    ALREADYUNLOCKED = 3'd2,
    CANNOTLOCK      = 3'd3,
    ALREADYLOCKED   = 3'd4,
    INVALID_OP      = 3'd5,
    ROUNDACTIVE     = 3'd6,
    TIMEOUTERR      = 3'd7
  } outerrors_t;

  typedef struct packed {
    logic [DATAWIDTH-1:0] C_data;
    opcodes_t             C_op;
    logic                 C_start;
  } fsminputs_t;

  typedef struct packed {
    logic                 ready;
    outerrors_t           err;
    logic                 roundOver;
    logic [DATAWIDTH-1:0] maxBid;
  } fsmoutputs_t;

  typedef enum logic [2:0] {
    IDLE, WAITRDY, ISSUE, CHECK, START, WAITOVER, DONE, FAIL
  } seqstate_t;

  // session configuration, frozen when go is accepted
  typedef struct packed {
    logic [DATAWIDTH-1:0] key;
    logic [DATAWIDTH-1:0] xval;
    logic [DATAWIDTH-1:0] yval;
    logic [DATAWIDTH-1:0] zval;
    logic [DATAWIDTH-1:0] timer;
    logic [DATAWIDTH-1:0] bidcharge;
    logic [2:0]           mask;
    logic [15:0]          roundlen;
  } seqcfg_t;

  function automatic opcodes_t step_op(input logic [2:0] step);
    case (step)
      3'd0:    return UNLOCK;
      3'd1:    return LOADX;
      3'd2:    return LOADY;
      3'd3:    return LOADZ;
      3'd4:    return SETMASK;
      3'd5:    return SETTIMER;
      3'd6:    return SETBIDCHARGE;
      default: return LOCK;
    endcase
  endfunction

  function automatic logic [DATAWIDTH-1:0] step_data(input seqcfg_t cfg, input logic [2:0] step);
    case (step)
      3'd1:    return cfg.xval;
      3'd2:    return cfg.yval;
      3'd3:    return cfg.zval;
      3'd4:    return {{(DATAWIDTH-3){1'b0}}, cfg.mask};
      3'd5:    return cfg.timer;
      3'd6:    return cfg.bidcharge;
      default: return cfg.key;
    endcase
  endfunction

endpackage

// File: rtl/bids22_ctrl_sequencer_if.sv
// Command/status link between a bid master and the auction FSM.
interface bids22interface;
  import bids22defs::*;

  fsminputs_t  cin;
  fsmoutputs_t cout;

  modport master (output cin, input cout);
  modport slave  (input cin, output cout);
endinterface

// File: rtl/bids22_ctrl_sequencer.sv
// Runs one configure/lock/round session on the auction FSM per accepted go,
// reporting done/fail, the failing step and the winning bid.
module bids22_ctrl_sequencer
  import bids22defs::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic [DATAWIDTH-1:0] key,
  input  logic [DATAWIDTH-1:0] xval,
  input  logic [DATAWIDTH-1:0] yval,
  input  logic [DATAWIDTH-1:0] zval,
  input  logic [2:0]           mask,
  input  logic [DATAWIDTH-1:0] timer,
  input  logic [DATAWIDTH-1:0] bidcharge,
  input  logic [15:0]          roundlen,
  bids22interface.master       fsm,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [3:0]           failstep,
  output logic [2:0]           failerr,
  output logic [DATAWIDTH-1:0] winbid
);

  localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  seqstate_t            state, state_nxt;
  seqcfg_t              cfg;
  logic [2:0]           step;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [15:0]          rl_cnt;
  opcodes_t             cur_op;
  logic [DATAWIDTH-1:0] cur_data;
  logic                 wait_hit;
  logic                 last_step;
  logic                 op_err;
  fsminputs_t           cin_c;

  assign cur_op    = step_op(step);
  assign cur_data  = step_data(cfg, step);
  assign wait_hit  = (wait_cnt == WAIT_LAST);
  assign last_step = (step == 3'(NUM_STEPS - 1));
  assign op_err    = (fsm.cout.err != NOERROR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (go) state_nxt = WAITRDY;
      WAITRDY: begin
        if (fsm.cout.ready) state_nxt = ISSUE;
        else if (wait_hit)  state_nxt = FAIL;
      end
      ISSUE:    state_nxt = CHECK;
      CHECK: begin
        if (op_err)         state_nxt = FAIL;
        else if (last_step) state_nxt = START;
        else                state_nxt = WAITRDY;
      end
      START:    if (rl_cnt == 16'd1) state_nxt = WAITOVER;
      WAITOVER: begin
        if (op_err)                  state_nxt = FAIL;
        else if (fsm.cout.roundOver) state_nxt = DONE;
        else if (wait_hit)           state_nxt = FAIL;
      end
      DONE, FAIL: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // wait counter restarts on every entry into WAITRDY/WAITOVER and only
  // advances while the awaited event is absent, so it never exceeds WAIT_LAST
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg      <= '0;
      step     <= '0;
      wait_cnt <= '0;
      rl_cnt   <= '0;
      failstep <= '0;
      failerr  <= '0;
      winbid   <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          cfg      <= '{key: key, xval: xval, yval: yval, zval: zval, timer: timer,
                        bidcharge: bidcharge, mask: mask, roundlen: roundlen};
          step     <= '0;
          wait_cnt <= '0;
          rl_cnt   <= '0;
          failstep <= '0;
          failerr  <= '0;
          winbid   <= '0;
        end
        WAITRDY: if (!fsm.cout.ready) begin
          if (wait_hit) begin
            failstep <= cur_op;
            failerr  <= TIMEOUTERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (op_err) begin
            failstep <= cur_op;
            failerr  <= fsm.cout.err;
          end else if (last_step) begin
            rl_cnt <= (cfg.roundlen == 16'd0) ? 16'd1 : cfg.roundlen;
          end else begin
            step     <= step + 3'd1;
            wait_cnt <= '0;
          end
        end
        START: begin
          if (rl_cnt == 16'd1) wait_cnt <= '0;
          else                 rl_cnt   <= rl_cnt - 16'd1;
        end
        WAITOVER: begin
          if (op_err) begin
            failstep <= WAITOVER_STEP;
            failerr  <= fsm.cout.err;
          end else if (fsm.cout.roundOver) begin
            winbid <= fsm.cout.maxBid;
          end else if (wait_hit) begin
            failstep <= WAITOVER_STEP;
            failerr  <= TIMEOUTERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs decode straight from state so reset drops C_start asynchronously
  always_comb begin
    cin_c = '0;
    busy  = (state != IDLE);
    done  = (state == DONE);
    fail  = (state == FAIL);
    case (state)
      ISSUE: begin
        cin_c.C_op   = cur_op;
        cin_c.C_data = cur_data;
      end
      START:   cin_c.C_start = 1'b1;
      default: ;
    endcase
  end

  assign fsm.cin = cin_c;

endmodule

// File: tb/tb_bids22_ctrl_sequencer.sv
// Directed session vectors against a small behavioural auction-FSM responder.
module tb_bids22_ctrl_sequencer;
  import bids22defs::*;

  localparam int TO       = 16;
  localparam int OV_DELAY = 2;

  logic                 clk = 1'b0, reset_n = 1'b0, go = 1'b0;
  logic [DATAWIDTH-1:0] key = '0, xval = '0, yval = '0, zval = '0, timer = '0, bidcharge = '0;
  logic [2:0]           mask = '0;
  logic [15:0]          roundlen = '0;
  logic                 busy, done, fail;
  logic [3:0]           failstep;
  logic [2:0]           failerr;
  logic [DATAWIDTH-1:0] winbid;

  bids22interface fsm_if ();

  bids22_ctrl_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .key(key), .xval(xval), .yval(yval),
    .zval(zval), .mask(mask), .timer(timer), .bidcharge(bidcharge), .roundlen(roundlen),
    .fsm(fsm_if), .busy(busy), .done(done), .fail(fail), .failstep(failstep),
    .failerr(failerr), .winbid(winbid)
  );

  always #5 clk = ~clk;

  // responder: err valid the cycle after an op, ready stall after stall_op,
  // roundOver OV_DELAY+1 cycles after C_start falls
  opcodes_t   bad_op = NO_OP, stall_op = NO_OP;
  outerrors_t bad_err = NOERROR, m_err = NOERROR;
  int         stall_len = 0, stall_cnt = 0, ov_cnt = -1;
  bit         ov_en = 1'b1;
  logic [31:0] m_maxbid = '0;

  always @(posedge clk) begin
    if (fsm_if.cin.C_op != NO_OP && fsm_if.cin.C_op == bad_op) m_err <= bad_err;
    else                                                         m_err <= NOERROR;
    if (fsm_if.cin.C_op != NO_OP && fsm_if.cin.C_op == stall_op) stall_cnt <= stall_len;
    else if (stall_cnt > 0)                                      stall_cnt <= stall_cnt - 1;
    if (fsm_if.cin.C_start) ov_cnt <= OV_DELAY;
    else if (ov_cnt > 0)    ov_cnt <= ov_cnt - 1;
  end

  assign fsm_if.cout = '{ready: (stall_cnt == 0), err: m_err,
                         roundOver: (ov_en && ov_cnt == 0), maxBid: m_maxbid};

  // monitor
  int          cyc = 0, n_done = 0, n_fail = 0, start_cnt = 0, last_start = 0;
  int          end_cyc = 0, lx_cyc = 0, gap = -1;
  opcodes_t    op_q[$];
  logic [31:0] data_q[$];

  always @(negedge clk) begin
    cyc++;
    if (fsm_if.cin.C_op != NO_OP) begin
      op_q.push_back(fsm_if.cin.C_op);
      data_q.push_back(fsm_if.cin.C_data);
      if (fsm_if.cin.C_op == LOADX) lx_cyc = cyc;
      if (fsm_if.cin.C_op == LOADY) gap = cyc - lx_cyc - 1;
    end
    if (fsm_if.cin.C_start) begin start_cnt++; last_start = cyc; end
    if (done) begin n_done++; end_cyc = cyc; end
    if (fail) begin n_fail++; end_cyc = cyc; end
  end

  task automatic clear_mon();
    n_done = 0; n_fail = 0; start_cnt = 0; last_start = 0; end_cyc = 0; gap = -1;
    op_q.delete(); data_q.delete();
  endtask

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] key, x, y, z, tmr, bc;
    logic [2:0]  msk;
    logic [15:0] rl;
    opcodes_t    bad_op;
    outerrors_t  bad_err;
    int          stall;
    bit          ov_en;
    logic [31:0] maxbid;
    int          go_again;
    bit          e_done;
    logic [3:0]  e_step;
    logic [2:0]  e_err;
    logic [31:0] e_win;
    int          e_start, e_nops, e_lat, e_gap;
  } vec_t;

  vec_t     vecs[6];
  opcodes_t exp_ops[8] = '{UNLOCK, LOADX, LOADY, LOADZ, SETMASK, SETTIMER, SETBIDCHARGE, LOCK};

  task automatic run_vec(input int vi);
    vec_t        v = vecs[vi];
    logic [31:0] exp_data[8];
    int          budget, lat;
    exp_data  = '{v.key, v.x, v.y, v.z, {29'b0, v.msk}, v.tmr, v.bc, v.key};
    bad_op    = v.bad_op;
    bad_err   = v.bad_err;
    stall_len = v.stall;
    stall_op  = (v.stall > 0) ? LOADX : NO_OP;
    ov_en     = v.ov_en;
    m_maxbid  = v.maxbid;
    @(posedge clk); #1 clear_mon();
    @(negedge clk);
    key = v.key; xval = v.x; yval = v.y; zval = v.z; mask = v.msk;
    timer = v.tmr; bidcharge = v.bc; roundlen = v.rl; go = 1'b1;
    @(negedge clk);
    // the session must ignore anything after acceptance
    go = 1'b0; key = ~v.key; xval = v.x + 1; yval = v.y + 1; zval = v.z + 1;
    mask = ~v.msk; timer = v.tmr + 1; bidcharge = v.bc + 1; roundlen = v.rl + 16'd7;
    if (v.go_again > 0) begin
      repeat (v.go_again) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    budget = 0;
    while (n_done + n_fail == 0 && budget < 2000) begin @(negedge clk); budget++; end
    chk($sformatf("v%0d.ended", vi), budget < 2000, 1);
    repeat (3) @(negedge clk);
    lat = (start_cnt > 0) ? end_cyc - last_start : -1;
    chk($sformatf("v%0d.done_cnt", vi), n_done, v.e_done);
    chk($sformatf("v%0d.fail_cnt", vi), n_fail, !v.e_done);
    chk($sformatf("v%0d.failstep", vi), failstep, v.e_step);
    chk($sformatf("v%0d.failerr", vi), failerr, v.e_err);
    chk($sformatf("v%0d.winbid", vi), winbid, v.e_win);
    chk($sformatf("v%0d.busy_after", vi), busy, 0);
    chk($sformatf("v%0d.start_cycles", vi), start_cnt, v.e_start);
    chk($sformatf("v%0d.num_ops", vi), op_q.size(), v.e_nops);
    chk($sformatf("v%0d.end_latency", vi), lat, v.e_lat);
    chk($sformatf("v%0d.loadx_loady_gap", vi), gap, v.e_gap);
    for (int i = 0; i < v.e_nops; i++) begin
      if (i < op_q.size()) begin
        chk($sformatf("v%0d.op%0d", vi, i), op_q[i], exp_ops[i]);
        chk($sformatf("v%0d.data%0d", vi, i), data_q[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, budget;
    //            key       x    y    z    tmr bc msk     rl      bad_op   bad_err     stall ov    maxbid ga
    //            | done step          err         win start nops lat gap
    vecs[0] = '{32'hA5A5, 100, 200, 300, 50, 1, 3'b111, 16'd5, NO_OP,   NOERROR,    0,  1'b1, 42, 0,
                1'b1, 4'd0,          3'd0,       42, 5, 8,  4,  2};
    vecs[1] = '{32'h1111, 10,  20,  30,  40, 1, 3'b111, 16'd5, UNLOCK,  BADKEY,     0,  1'b1, 42, 0,
                1'b0, UNLOCK,        BADKEY,     0,  0, 1, -1, -1};
    vecs[2] = '{32'h1234, 7,   8,   9,   20, 2, 3'b101, 16'd3, NO_OP,   NOERROR,    10, 1'b1, 99, 0,
                1'b1, 4'd0,          3'd0,       99, 3, 8,  4, 11};
    vecs[3] = '{32'hBEEF, 1,   2,   3,   9,  4, 3'b010, 16'd2, NO_OP,   NOERROR,    0,  1'b0, 55, 0,
                1'b0, WAITOVER_STEP, TIMEOUTERR, 0,  2, 8, 17,  2};
    vecs[4] = '{32'hCAFE, 11,  22,  33,  60, 3, 3'b011, 16'd0, NO_OP,   NOERROR,    0,  1'b1, 7,  3,
                1'b1, 4'd0,          3'd0,       7,  1, 8,  4,  2};
    vecs[5] = '{32'h5A5A, 4,   5,   6,   70, 5, 3'b110, 16'd4, SETMASK, INVALID_OP, 0,  1'b1, 42, 0,
                1'b0, SETMASK,       INVALID_OP, 0,  0, 5, -1,  2};

    repeat (2) @(negedge clk);
    chk("rst.cin", fsm_if.cin, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.fail", fail, 0);
    chk("rst.failstep", failstep, 0);
    chk("rst.failerr", failerr, 0);
    chk("rst.winbid", winbid, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle.busy", busy, 0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // reset during the third of five START cycles
    bad_op = NO_OP; stall_op = NO_OP; ov_en = 1'b1; m_maxbid = 42;
    @(posedge clk); #1 clear_mon();
    @(negedge clk);
    key = 32'hA5A5; xval = 100; yval = 200; zval = 300; mask = 3'b111;
    timer = 50; bidcharge = 1; roundlen = 16'd5; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    k = 0; budget = 0;
    while (k < 3 && budget < 500) begin
      @(negedge clk);
      budget++;
      if (fsm_if.cin.C_start) k++;
    end
    chk("rst_mid.start_cycles_seen", k, 3);
    reset_n = 1'b0;
    #1;
    chk("rst_mid.c_start", fsm_if.cin.C_start, 0);
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.cin", fsm_if.cin, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid.no_pulse", n_done + n_fail, 0);
    chk("rst_mid.busy_after", busy, 0);
    chk("rst_mid.winbid", winbid, 0);
    chk("rst_mid.failstep", failstep, 0);

    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
